// File: rtl/datapath_sequencer.sv
// Command sequencer for the register-file/ALU datapath: accepts one command per
// handshake and steps it through execute/write-back iterations until done.
module datapath_sequencer #(
    parameter int unsigned NLOC  = 32,
    parameter int unsigned DBITS = 8,
    parameter int unsigned CNTW  = 4,
    localparam int unsigned AW   = $clog2(NLOC)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [4:0]       cmd_alufn,
    input  logic [AW-1:0]    cmd_rd,
    input  logic [AW-1:0]    cmd_rs1,
    input  logic [AW-1:0]    cmd_rs2,
    input  logic [DBITS-1:0] cmd_imm,
    input  logic [CNTW-1:0]  cmd_count,
    output logic             RegWrite,
    output logic [AW-1:0]    ReadAddr1,
    output logic [AW-1:0]    ReadAddr2,
    output logic [AW-1:0]    WriteAddr,
    output logic [4:0]       ALUFN,
    output logic [DBITS-1:0] WriteData,
    input  logic [DBITS-1:0] ALUResult,
    input  logic             FlagZ,
    output logic             done,
    output logic [DBITS-1:0] result,
    output logic             zero,
    output logic [CNTW:0]    iters
);

    localparam logic [1:0] ModeRr     = 2'b00;
    localparam logic [1:0] ModeLi     = 2'b01;
    localparam logic [1:0] ModeRep    = 2'b10;
    localparam logic [1:0] ModeUntilz = 2'b11;

    typedef enum logic [1:0] {StIdle, StExec, StWb, StDone} state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic               w_handshake;
    logic               w_loop;
    logic               w_finish;

    logic [1:0]         r_mode;
    logic [AW-1:0]      r_rd;
    logic [AW-1:0]      r_ra1;
    logic [AW-1:0]      r_ra2;
    logic [AW-1:0]      r_wa;
    logic [4:0]         r_alufn;
    logic [DBITS-1:0]   r_res;
    logic               r_z;
    logic [CNTW-1:0]    r_rem;
    logic [CNTW:0]      r_cnt;
    logic [DBITS-1:0]   r_result;
    logic               r_zero;
    logic [CNTW:0]      r_iters;

    always_comb begin
        w_state_next = r_state;
        w_handshake  = (r_state == StIdle) && cmd_valid && !reset;
        unique case (r_state)
            StIdle: begin
                if (w_handshake) begin
                    w_state_next = (cmd_mode == ModeLi) ? StWb : StExec;
                end
            end
            StExec: w_state_next = StWb;
            StWb: begin
                unique case (r_mode)
                    ModeRep:    w_state_next = (r_rem != '0) ? StExec : StDone;
                    ModeUntilz: w_state_next = (r_z || r_rem == '0) ? StDone : StExec;
                    default:    w_state_next = StDone;
                endcase
            end
            StDone: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
        w_loop   = (r_state == StWb) && (w_state_next == StExec);
        w_finish = (r_state == StWb) && (w_state_next == StDone);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mode   <= ModeRr;
            r_rd     <= '0;
            r_ra1    <= '0;
            r_ra2    <= '0;
            r_wa     <= '0;
            r_alufn  <= '0;
            r_res    <= '0;
            r_z      <= 1'b0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_iters  <= '0;
        end else begin
            if (w_handshake) begin
                r_mode <= cmd_mode;
                r_rd   <= cmd_rd;
                r_wa   <= cmd_rd;
                r_rem  <= cmd_count;
                r_cnt  <= '0;
                r_z    <= 1'b0;
                // LI leaves the ALU-facing outputs untouched and writes the immediate.
                if (cmd_mode == ModeLi) begin
                    r_res <= cmd_imm;
                end else begin
                    r_ra1   <= cmd_rs1;
                    r_ra2   <= cmd_rs2;
                    r_alufn <= cmd_alufn;
                end
            end
            if (r_state == StExec) begin
                r_res <= ALUResult;
                r_z   <= FlagZ;
                r_cnt <= r_cnt + 1'b1;
            end
            // Later iterations accumulate into rd.
            if (w_loop) begin
                r_ra1 <= r_rd;
                r_rem <= r_rem - 1'b1;
            end
            if (w_finish) begin
                r_result <= r_res;
                r_zero   <= r_z;
                r_iters  <= r_cnt;
            end
        end
    end

    assign cmd_ready = (r_state == StIdle) && !reset;
    assign RegWrite  = (r_state == StWb) && !reset;
    assign done      = (r_state == StDone) && !reset;
    assign ReadAddr1 = r_ra1;
    assign ReadAddr2 = r_ra2;
    assign WriteAddr = r_wa;
    assign ALUFN     = r_alufn;
    assign WriteData = r_res;
    assign result    = r_result;
    assign zero      = r_zero;
    assign iters     = r_iters;

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Command-driven controller that sequences the register-file/ALU datapath. It accepts one command at a time over a valid/ready handshake and drives the datapath's read addresses, ALU function, write address, write data and write enable. It supports single operations, immediate loads, repeated accumulation and loop-until-zero. It sits between the instruction/test source and the datapath and is the only writer of the register file.

## Interface
- NLOC, 32, register-file depth; address width AW = $clog2(NLOC)
- DBITS, 8, data width
- CNTW, 4, repeat-count width
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_mode  in  2  00 RR, 01 LI, 10 REP, 11 UNTILZ
- cmd_alufn  in  5  ALU function, passed to ALUFN unchanged
- cmd_rd, cmd_rs1, cmd_rs2  in  AW each  destination / source registers
- cmd_imm  in  DBITS  immediate for LI
- cmd_count  in  CNTW  extra iterations for REP/UNTILZ
- RegWrite  out  1  register-file write enable
- ReadAddr1, ReadAddr2, WriteAddr  out  AW  datapath addresses
- ALUFN  out  5  ALU function
- WriteData  out  DBITS  register-file write data
- ALUResult  in  DBITS  combinational ALU output
- FlagZ  in  1  ALU zero flag
- done  out  1  one-cycle pulse when a command completes
- result  out  DBITS  last value written; held until the next write
- zero  out  1  FlagZ of the last ALU iteration (0 for LI)
- iters  out  CNTW+1  ALU iterations performed by the last command

## Operation
- The command is latched into internal registers on the handshake cmd_valid & cmd_ready. The datapath outputs come only from these latched fields, never directly from the cmd_* inputs.
- States:
  - IDLE: cmd_ready=1. On handshake, go to WB if mode=LI, else to EXEC.
  - EXEC: drive the ALU inputs and capture the ALU output.
    - ReadAddr1 = rs1 on the first iteration, rd on later iterations. ReadAddr2 = rs2. ALUFN = alufn.
    - At the clock edge: res_q <= ALUResult, z_q <= FlagZ, iteration counter += 1. Then go to WB.
  - WB: write the result back.
    - RegWrite = !reset. WriteAddr = rd. WriteData = res_q (imm for LI).
    - Next state:
      - RR and LI go to DONE.
      - REP returns to EXEC while remaining > 0 (remaining decrements on each WB); otherwise DONE.
      - UNTILZ goes to DONE when z_q=1 or remaining=0; otherwise it returns to EXEC.
  - DONE: done=1 and update result/zero/iters, then go to IDLE.
- Iteration counts:
  - REP performs exactly cmd_count+1 ALU iterations.
  - UNTILZ performs 1 to cmd_count+1 ALU iterations.
  - The zero-result iteration is still written back.
- Arithmetic is done entirely by the datapath; the sequencer does no arithmetic on data. Internal counters are unsigned: remaining is CNTW bits, iters is CNTW+1 bits and never wraps.
- rd equal to rs1 or rs2 is legal. Each EXEC reads register contents as they stand after every previous WB, because the register file writes on the WB edge.
- RegWrite is 0 in every state except WB.
- Between commands, address, ALUFN and WriteData outputs hold their last values.

## Timing
- Reset values: state IDLE, RegWrite 0, cmd_ready 0 while reset is high (1 on the first cycle after), done 0, result 0, zero 0, iters 0, all address/ALUFN/WriteData outputs 0.
- Latency, with the handshake in cycle T:
  - RR: EXEC at T+1, WB at T+2, done at T+3, next handshake possible at T+4.
  - LI: WB at T+1, done at T+2, ready again at T+3.
  - REP/UNTILZ with k iterations: done at T+1+2k.
- cmd_ready is low from the cycle after a handshake until the sequencer returns to IDLE. cmd_* inputs may change freely while cmd_ready=0.
- Reset mid-command:
  - The command is aborted at that edge and state returns to IDLE.
  - If reset is high during a WB cycle, RegWrite is forced 0 and no write occurs.
  - No done pulse is produced for an aborted command.
- cmd_count=0 makes REP and UNTILZ each do exactly one iteration, the same as RR.

## Test plan
Test values assume bench ALU encoding 5'b00000=add, 5'b01000=sub.
- **Reset:** hold reset 3 cycles with cmd_valid=1 -> no handshake, RegWrite never 1, all outputs 0; cmd_ready=1 on the first cycle after reset.
- **LI then RR:** LI r1=5, then LI r2=3, then RR add r3=r1+r2 -> r3=8, result=8, zero=0, iters=1; done is exactly 3 cycles after the RR handshake.
- **REP accumulate:** with r1=5, r2=3, REP add rd=r4, rs1=r1, rs2=r2, count=3 -> 4 writes to r4 (8, 11, 14, 17), result=17, iters=4; done at handshake+9.
- **UNTILZ early exit:** with r5=9, r6=3, UNTILZ sub rd=r5, rs1=r5, rs2=r6, count=15 -> writes 6, 3, 0 then stops; zero=1, iters=3, r5=0.
- **Self-reference:** RR add rd=r1, rs1=r1, rs2=r1 with r1=7 -> r1=14, single write.
- **Reset during WB:** assert reset in the first WB cycle of REP count=2 -> RegWrite stays 0 that cycle, target register unchanged, no done pulse, state returns to IDLE.
